operand_loader: RTL and testbench

- Consumes the synchronised button level from the input synchroniser stage, together with the board switches.
- Converts button presses into a sequenced operand-entry FSM: press 1 captures operand A, press 2 captures operand B and fires a one-cycle start to the multiplier.
- It then waits for the multiplier's done, latches the product for display, and on press 3 returns to operand entry.
- Press detection includes rising-edge detection plus a lockout counter, which absorbs residual contact bounce that survives synchronisation.

---
 rtl/operand_loader_if.sv | 27 ++
 rtl/operand_loader.sv | 111 +++++++++++
 tb/tb_operand_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/operand_loader_if.sv
// Bus between the operand loader and its environment: button/switch inputs,
// the multiplier handshake and the operand/result/status outputs.
interface operand_loader_if #(
  parameter int WIDTH = 4
);
  logic               btn;
  logic [WIDTH-1:0]   sw;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               mul_start;
  logic [2*WIDTH-1:0] result;
  logic               result_valid;
  logic               err;
  logic [2:0]         state;

  modport master (
    output btn, sw, mul_done, mul_product,
    input  op_a, op_b, mul_start, result, result_valid, err, state
  );

  modport slave (
    input  btn, sw, mul_done, mul_product,
    output op_a, op_b, mul_start, result, result_valid, err, state
  );
endinterface

// File: rtl/operand_loader.sv
// Button-driven operand entry: press 1 loads A, press 2 loads B and starts the
// multiplier, the product is shown until press 3 returns to entry.
module operand_loader #(
  parameter int WIDTH          = 4,
  parameter int LOCKOUT_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_loader_if.slave bus
);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  state_t             st;
  logic               btn_q;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [WIDTH-1:0]   cap_a;
  logic [WIDTH-1:0]   cap_b;
  logic               start_pulse;
  logic [2*WIDTH-1:0] prod;
  logic               prod_vld;
  logic               tmo_err;
  logic               press;
  logic               accept;

  // Presses outside the entry/show states are dropped without re-arming the lockout.
  assign press  = bus.btn & ~btn_q & (lock_cnt == '0);
  assign accept = press & ((st == LOAD_A) | (st == LOAD_B) | (st == SHOW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= LOAD_A;
      btn_q       <= 1'b1;
      lock_cnt    <= '0;
      tmo_cnt     <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      start_pulse <= 1'b0;
      prod        <= '0;
      prod_vld    <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      btn_q       <= bus.btn;
      start_pulse <= 1'b0;

      if (accept)
        lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
      else if (lock_cnt != '0)
        lock_cnt <= lock_cnt - LOCK_W'(1);

      case (st)
        LOAD_A: begin
          if (press) begin
            cap_a <= bus.sw;
            st    <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            cap_b       <= bus.sw;
            start_pulse <= 1'b1;
            st          <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          st      <= WAIT;
        end
        WAIT: begin
          // Done has priority over a timeout falling in the same cycle.
          if (bus.mul_done) begin
            prod     <= bus.mul_product;
            prod_vld <= 1'b1;
            st       <= SHOW;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_err <= 1'b1;
            st      <= SHOW;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        SHOW: begin
          if (press) begin
            prod_vld <= 1'b0;
            tmo_err  <= 1'b0;
            st       <= LOAD_A;
          end
        end
        default: st <= LOAD_A;
      endcase
    end
  end

  assign bus.op_a         = cap_a;
  assign bus.op_b         = cap_b;
  assign bus.mul_start    = start_pulse;
  assign bus.result       = prod;
  assign bus.result_valid = prod_vld;
  assign bus.err          = tmo_err;
  assign bus.state        = st;
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with short lockout/timeout values.
module tb_operand_loader;
  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  int   starts;

  operand_loader_if #(.WIDTH(4)) bus ();

  operand_loader #(
    .WIDTH         (4),
    .LOCKOUT_CYCLES(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.mul_start === 1'b1) starts++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_btn(input logic [3:0] val);
    bus.sw  = val;
    bus.btn = 1'b1;
    tick();
    bus.btn = 1'b0;
  endtask

  // Clean rising edges n cycles apart; switches change between the two.
  task automatic edge_pair(input int n, input logic [3:0] va, input logic [3:0] vb);
    press_btn(va);
    bus.sw = vb;
    tick(n - 1);
    press_btn(vb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_op_a"}, 32'(bus.op_a), 0);
    chk({pfx, "_op_b"}, 32'(bus.op_b), 0);
    chk({pfx, "_result"}, 32'(bus.result), 0);
    chk({pfx, "_mul_start"}, 32'(bus.mul_start), 0);
    chk({pfx, "_result_valid"}, 32'(bus.result_valid), 0);
    chk({pfx, "_err"}, 32'(bus.err), 0);
    chk({pfx, "_state"}, 32'(bus.state), 0);
  endtask

  initial begin
    int s0;
    tests           = 0;
    failed          = 0;
    starts          = 0;
    rst_n           = 1'b0;
    bus.btn         = 1'b0;
    bus.sw          = 4'd0;
    bus.mul_done    = 1'b0;
    bus.mul_product = 8'd0;
    tick(2);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // Normal flow: 3 x 5 = 15
    press_btn(4'd3);
    chk("nf_state_b", 32'(bus.state), 1);
    chk("nf_op_a", 32'(bus.op_a), 3);
    tick(10);
    press_btn(4'd5);
    chk("nf_start_hi", 32'(bus.mul_start), 1);
    chk("nf_state_start", 32'(bus.state), 2);
    chk("nf_op_b", 32'(bus.op_b), 5);
    tick();
    chk("nf_start_lo", 32'(bus.mul_start), 0);
    chk("nf_state_wait", 32'(bus.state), 3);
    tick(3);
    bus.mul_done    = 1'b1;
    bus.mul_product = 8'd15;
    tick();
    bus.mul_done    = 1'b0;
    bus.mul_product = 8'd0;
    chk("nf_result", 32'(bus.result), 15);
    chk("nf_result_valid", 32'(bus.result_valid), 1);
    chk("nf_err", 32'(bus.err), 0);
    chk("nf_state_show", 32'(bus.state), 4);
    chk("nf_start_count", 32'(starts), 1);
    bus.sw = 4'd9;
    tick(10);
    chk("nf_show_hold", 32'(bus.result), 15);
    press_btn(4'd9);
    chk("nf_back_load_a", 32'(bus.state), 0);
    chk("nf_rv_cleared", 32'(bus.result_valid), 0);
    chk("nf_op_a_kept", 32'(bus.op_a), 3);
    chk("nf_op_b_kept", 32'(bus.op_b), 5);

    // Stray done in LOAD_A
    tick(10);
    bus.mul_done    = 1'b1;
    bus.mul_product = 8'hAA;
    tick();
    bus.mul_done    = 1'b0;
    tick();
    chk("stray_state", 32'(bus.state), 0);
    chk("stray_result", 32'(bus.result), 15);
    chk("stray_rv", 32'(bus.result_valid), 0);

    // Bounce: 1,0,1,0,1 on consecutive cycles
    do_reset();
    press_btn(4'd7);
    bus.sw = 4'd9;
    tick();
    bus.btn = 1'b1; tick();
    bus.btn = 1'b0; tick();
    bus.btn = 1'b1; tick();
    bus.btn = 1'b0;
    chk("bnc_state", 32'(bus.state), 1);
    chk("bnc_op_a", 32'(bus.op_a), 7);
    chk("bnc_op_b", 32'(bus.op_b), 0);

    // Second edge 7 cycles after the first is ignored
    do_reset();
    edge_pair(7, 4'd1, 4'd4);
    chk("lock7_state", 32'(bus.state), 1);
    chk("lock7_op_a", 32'(bus.op_a), 1);
    chk("lock7_op_b", 32'(bus.op_b), 0);

    // Second edge 9 cycles after the first is accepted, then time out
    do_reset();
    s0 = starts;
    edge_pair(9, 4'd1, 4'd6);
    chk("lock9_state", 32'(bus.state), 2);
    chk("lock9_op_b", 32'(bus.op_b), 6);
    chk("lock9_start", 32'(bus.mul_start), 1);
    tick();
    chk("tmo_enter_wait", 32'(bus.state), 3);
    tick(15);
    chk("tmo_err_early", 32'(bus.err), 0);
    chk("tmo_state_early", 32'(bus.state), 3);
    tick();
    chk("tmo_err", 32'(bus.err), 1);
    chk("tmo_state_show", 32'(bus.state), 4);
    chk("tmo_rv", 32'(bus.result_valid), 0);
    chk("tmo_result", 32'(bus.result), 0);
    chk("tmo_start_count", 32'(starts - s0), 1);
    press_btn(4'd0);
    chk("tmo_back_state", 32'(bus.state), 0);
    chk("tmo_err_cleared", 32'(bus.err), 0);

    // Done in the last WAIT cycle wins over timeout: 2 x 3 = 6
    tick(10);
    press_btn(4'd2);
    tick(10);
    press_btn(4'd3);
    tick();
    chk("col_wait", 32'(bus.state), 3);
    tick(15);
    bus.mul_done    = 1'b1;
    bus.mul_product = 8'd6;
    tick();
    bus.mul_done    = 1'b0;
    chk("col_result", 32'(bus.result), 6);
    chk("col_rv", 32'(bus.result_valid), 1);
    chk("col_err", 32'(bus.err), 0);
    chk("col_state", 32'(bus.state), 4);

    // Button held through reset release
    bus.btn = 1'b1;
    rst_n   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("hold_state", 32'(bus.state), 0);
    chk("hold_op_a", 32'(bus.op_a), 0);
    bus.btn = 1'b0;
    tick(2);

    // Asynchronous reset in WAIT with done pending
    press_btn(4'd2);
    tick(10);
    press_btn(4'd3);
    tick();
    chk("arst_in_wait", 32'(bus.state), 3);
    s0 = starts;
    bus.mul_done    = 1'b1;
    bus.mul_product = 8'd6;
    rst_n           = 1'b0;
    #1;
    chk_reset_outputs("arst");
    tick(2);
    rst_n        = 1'b1;
    bus.mul_done = 1'b0;
    tick(4);
    chk("arst_no_start", 32'(starts - s0), 0);
    chk("arst_state_after", 32'(bus.state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
